// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard/control bundle between the 5-stage datapath (master) and the
// stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] if_id_rs;
  logic [REG_W-1:0] if_id_rt;
  logic             if_id_uses_rt;
  logic             id_ex_mem_read;
  logic [REG_W-1:0] id_ex_rt;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ack;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             stall;

  modport master (
    output if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
           branch_taken, mem_req, mem_ack,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, stall
  );

  modport slave (
    input  if_id_rs, if_id_rt, if_id_uses_rt, id_ex_mem_read, id_ex_rt,
           branch_taken, mem_req, mem_ack,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, stall
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (load-use, branch
// squash, data-memory wait). Define PIPE_CTRL_PERF_EN to add stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o,
`endif
  pipeline_hazard_ctrl_if.slave hz_if
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;

  logic pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic ifidFlush, idexFlush, exmemFlush;
  logic memWait, loadUse, waitNow;

  assign memWait = hz_if.mem_req & ~hz_if.mem_ack;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign loadUse = hz_if.id_ex_mem_read && (hz_if.id_ex_rt != '0) &&
                   ((hz_if.id_ex_rt == hz_if.if_id_rs) ||
                    (hz_if.if_id_uses_rt && (hz_if.id_ex_rt == hz_if.if_id_rt)));

  // Once in MEM_WAIT only the ack releases the pipe, even if mem_req drops.
  assign waitNow = (state_q == MEM_WAIT) ? ~hz_if.mem_ack : memWait;

  always_comb begin
    pcEn       = 1'b1;
    ifidEn     = 1'b1;
    idexEn     = 1'b1;
    exmemEn    = 1'b1;
    memwbEn    = 1'b1;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    state_d    = state_q;
    fcnt_d     = fcnt_q;

    unique case (state_q)
      INIT: begin
        {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
        {ifidFlush, idexFlush, exmemFlush}       = 3'b111;
        state_d = RUN;
      end

      RUN, MEM_WAIT: begin
        if (waitNow) begin
          {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
          state_d = MEM_WAIT;
        end else if (hz_if.branch_taken) begin
          {ifidFlush, idexFlush, exmemFlush} = 3'b111;
          fcnt_d  = FLUSH_LOAD;
          state_d = (FLUSH_LOAD == 3'd0) ? RUN : FLUSH;
        end else if (loadUse && (state_q == RUN)) begin
          pcEn      = 1'b0;
          ifidEn    = 1'b0;
          idexFlush = 1'b1;
          state_d   = RUN;
        end else begin
          state_d = RUN;
        end
      end

      FLUSH: begin
        // Squashed slots cannot branch, so branch_taken is not looked at here.
        if (memWait) begin
          {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
        end else begin
          ifidFlush = 1'b1;
          fcnt_d    = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            fcnt_d  = 3'd0;
            state_d = RUN;
          end
        end
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign hz_if.pc_en       = pcEn;
  assign hz_if.ifid_en     = ifidEn;
  assign hz_if.idex_en     = idexEn;
  assign hz_if.exmem_en    = exmemEn;
  assign hz_if.memwb_en    = memwbEn;
  assign hz_if.ifid_flush  = ifidFlush;
  assign hz_if.idex_flush  = idexFlush;
  assign hz_if.exmem_flush = exmemFlush;
  assign hz_if.stall       = ~(pcEn & ifidEn & idexEn & exmemEn & memwbEn);

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q;

  // Saturating counters; the reset-like INIT cycle is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else if (state_q != INIT) begin
      if (hz_if.stall && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + 1'b1;
      if (ifidFlush && (flushCnt_q != '1))   flushCnt_q <= flushCnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;
`endif

endmodule
